// File: rtl/parity_tx_if.sv
// rtl/parity_tx_if.sv - parallel-in / serial-out handshake bundle for parity_tx
interface parity_tx_if #(
    parameter int DATA_WIDTH = 8
);
    // Parallel word side
    logic [DATA_WIDTH-1:0] dataIn;
    logic                  dataValid;
    logic                  dataReady;

    // Serial frame side
    logic                  seqReady;
    logic                  seqOut;
    logic                  seqValid;
    logic                  lastOut;

    // Producer of words / consumer of serial bits
    modport master (
        output dataIn,
        output dataValid,
        input  dataReady,
        output seqReady,
        input  seqOut,
        input  seqValid,
        input  lastOut
    );

    // The serialiser itself
    modport slave (
        input  dataIn,
        input  dataValid,
        output dataReady,
        input  seqReady,
        output seqOut,
        output seqValid,
        output lastOut
    );
endinterface

// File: rtl/parity_tx.sv
// rtl/parity_tx.sv - word serialiser, LSB first, with trailing even/odd parity bit
module parity_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic       clk,
    input  logic       rst,
    parity_tx_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY
    } state_t;

    localparam int             CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    // Seeding the accumulator with the parity sense makes the final
    // accumulator value the bit that completes the frame's ones count.
    localparam logic           ACC_INIT = (ODD_PARITY != 0);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  acc_q;
    logic                  seq_out_q;
    logic                  seq_valid_q;
    logic                  last_q;

    logic                  data_ready;
    logic                  word_xfer;
    logic                  bit_xfer;

    // Ready in Idle, or in Parity when the parity bit leaves this cycle so the
    // next frame follows with no gap; forced low while reset is held.
    assign data_ready = rst & ((state == ST_IDLE) |
                               ((state == ST_PARITY) & bus.seqReady));
    assign word_xfer  = bus.dataValid & data_ready;
    assign bit_xfer   = seq_valid_q & bus.seqReady;

    assign bus.dataReady = data_ready;
    assign bus.seqOut    = seq_out_q;
    assign bus.seqValid  = seq_valid_q;
    assign bus.lastOut   = last_q;

    // Frame FSM; the serial outputs are registered alongside the state so the
    // bit presented always matches the state it was computed for.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt     <= '0;
            acc_q       <= ACC_INIT;
            seq_out_q   <= 1'b0;
            seq_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else if (word_xfer) begin
            // Either from Idle or the parity bit leaving: start a new frame.
            state       <= ST_DATA;
            shift_q     <= bus.dataIn;
            bit_cnt     <= '0;
            acc_q       <= ACC_INIT;
            seq_out_q   <= bus.dataIn[0];
            seq_valid_q <= 1'b1;
            last_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    seq_valid_q <= 1'b0;
                    seq_out_q   <= 1'b0;
                    last_q      <= 1'b0;
                end
                ST_DATA: begin
                    if (bit_xfer) begin
                        acc_q   <= acc_q ^ shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state     <= ST_PARITY;
                            seq_out_q <= acc_q ^ shift_q[0];
                            last_q    <= 1'b1;
                        end else begin
                            seq_out_q <= shift_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_xfer) begin
                        state       <= ST_IDLE;
                        seq_valid_q <= 1'b0;
                        seq_out_q   <= 1'b0;
                        last_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    seq_valid_q <= 1'b0;
                    seq_out_q   <= 1'b0;
                    last_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parity_tx.sv
// tb/tb_parity_tx.sv - self-checking bench for parity_tx
module tb_parity_tx;
    logic clk;
    logic rst;

    int tests;
    int fails;

    logic [7:0] words [16];

    parity_tx_if #(.DATA_WIDTH(8)) bus   ();
    parity_tx_if #(.DATA_WIDTH(8)) bus_o ();

    parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    parity_tx #(.DATA_WIDTH(8), .ODD_PARITY(1)) u_dut_odd (
        .clk (clk),
        .rst (rst),
        .bus (bus_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams words[0..n-1] back to back through the even-parity DUT while a
    // reference queue of expected frame bits is built from the words alone.
    task automatic run_stream(input int n, input int stall_pct,
                              input int stall_at, input int stall_len);
        bit         eq[$];
        bit         lq[$];
        int         wi;
        int         done;
        int         cycles;
        int         valid_cycles;
        int         stall_left;
        int         ones;
        bit         sr;
        bit         exp_last;
        bit         forced;
        logic       obs_out;
        logic       obs_last;
        logic [7:0] w;

        stall_left   = stall_len;
        done         = 0;
        cycles       = 0;
        valid_cycles = 0;
        ones         = 0;

        bus.seqReady  = 1'b1;
        bus.dataValid = 1'b1;
        bus.dataIn    = words[0];
        #1;
        check("idle_ready", 32'(bus.dataReady), 32'd1);
        check("idle_valid", 32'(bus.seqValid), 32'd0);
        tick();
        wi = 1;
        w  = words[0];
        for (int k = 0; k < 8; k++) begin
            eq.push_back(w[k]);
            lq.push_back(1'b0);
        end
        eq.push_back(^w);
        lq.push_back(1'b1);

        while (eq.size() > 0 && cycles < 2000) begin
            cycles++;
            forced = 1'b0;
            if (done == stall_at && stall_left > 0) begin
                sr     = 1'b0;
                forced = 1'b1;
                stall_left--;
            end else begin
                sr = ($urandom_range(99) >= stall_pct);
            end
            exp_last     = lq[0];
            bus.seqReady = sr;
            if (wi < n) begin
                bus.dataValid = 1'b1;
                bus.dataIn    = words[wi];
            end else begin
                bus.dataValid = exp_last ? 1'b0 : 1'($urandom_range(1));
                bus.dataIn    = 8'($urandom);
            end
            #1;
            obs_out  = bus.seqOut;
            obs_last = bus.lastOut;
            if (bus.seqValid === 1'b1) valid_cycles++;
            check("seq_valid", 32'(bus.seqValid), 32'd1);
            check("seq_out", 32'(obs_out), 32'(eq[0]));
            check("last_out", 32'(obs_last), 32'(exp_last));
            check("data_ready", 32'(bus.dataReady), 32'(exp_last & sr));
            if (forced)
                check("stall_cnt_hold", 32'(u_dut.bit_cnt), 32'(done % 9));
            tick();
            if (sr) begin
                ones += int'(obs_out);
                if (obs_last === 1'b1) begin
                    check("even_detect", 32'(ones % 2), 32'd0);
                    ones = 0;
                end
                void'(eq.pop_front());
                void'(lq.pop_front());
                done++;
                if (exp_last && wi < n) begin
                    w = words[wi];
                    for (int k = 0; k < 8; k++) begin
                        eq.push_back(w[k]);
                        lq.push_back(1'b0);
                    end
                    eq.push_back(^w);
                    lq.push_back(1'b1);
                    wi++;
                end
            end
        end
        if (eq.size() > 0) check("stream_timeout", 32'd1, 32'd0);
        if (stall_pct == 0 && stall_len == 0)
            check("consecutive_valid", 32'(valid_cycles), 32'(9 * n));

        bus.seqReady  = 1'b1;
        bus.dataValid = 1'b0;
        #1;
        check("end_valid", 32'(bus.seqValid), 32'd0);
        check("end_out", 32'(bus.seqOut), 32'd0);
        check("end_last", 32'(bus.lastOut), 32'd0);
        check("end_ready", 32'(bus.dataReady), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;

        // Reset with inputs active: nothing may start.
        rst             = 1'b0;
        bus.dataIn      = 8'hA5;
        bus.dataValid   = 1'b1;
        bus.seqReady    = 1'b1;
        bus_o.dataIn    = 8'h00;
        bus_o.dataValid = 1'b0;
        bus_o.seqReady  = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(bus.seqValid), 32'd0);
        check("rst_out", 32'(bus.seqOut), 32'd0);
        check("rst_last", 32'(bus.lastOut), 32'd0);
        check("rst_ready", 32'(bus.dataReady), 32'd0);
        check("rst_acc", 32'(u_dut_odd.acc_q), 32'd1);
        check("rst_odd_ready", 32'(bus_o.dataReady), 32'd0);
        bus.dataValid = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(bus.dataReady), 32'd1);
        check("post_rst_valid", 32'(bus.seqValid), 32'd0);

        // 0xA5 and 0x07, even parity
        words[0] = 8'hA5;
        run_stream(1, 0, -1, 0);
        words[0] = 8'h07;
        run_stream(1, 0, -1, 0);

        // Odd parity instance, all-zero word: eight 0s then parity 1.
        bus_o.dataIn    = 8'h00;
        bus_o.dataValid = 1'b1;
        #1;
        check("odd_ready", 32'(bus_o.dataReady), 32'd1);
        tick();
        bus_o.dataValid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("odd_valid", 32'(bus_o.seqValid), 32'd1);
            check("odd_out", 32'(bus_o.seqOut), (i == 8) ? 32'd1 : 32'd0);
            check("odd_last", 32'(bus_o.lastOut), (i == 8) ? 32'd1 : 32'd0);
            tick();
        end
        check("odd_end_valid", 32'(bus_o.seqValid), 32'd0);

        // Back to back 0x01, 0x03
        words[0] = 8'h01;
        words[1] = 8'h03;
        run_stream(2, 0, -1, 0);

        // 0xF0 with a three-cycle stall while bit 4 is presented
        words[0] = 8'hF0;
        run_stream(1, 0, 4, 3);

        // Reset while bit 5 of 0xFF is on the line
        bus.dataIn    = 8'hFF;
        bus.dataValid = 1'b1;
        bus.seqReady  = 1'b1;
        tick();
        bus.dataValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("ff_bit", 32'(bus.seqOut), 32'd1);
            tick();
        end
        check("ff_bit5", 32'(bus.seqOut), 32'd1);
        check("ff_bit5_last", 32'(bus.lastOut), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(bus.seqValid), 32'd0);
        check("abort_out", 32'(bus.seqOut), 32'd0);
        check("abort_ready", 32'(bus.dataReady), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("abort_idle_valid", 32'(bus.seqValid), 32'd0);
        check("abort_idle_last", 32'(bus.lastOut), 32'd0);
        check("abort_idle_ready", 32'(bus.dataReady), 32'd1);
        words[0] = 8'h80;
        run_stream(1, 0, -1, 0);

        // Random streams with random backpressure
        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) words[k] = 8'($urandom);
            run_stream(n, int'($urandom_range(0, 50)), -1, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/parity_tx.md
PARITY_TX -- requirements
Module: parity_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of payload bits per frame (legal range 2..32).
REQ-002 Parameter ODD_PARITY, default 0, selects even parity when 0 and odd parity when 1.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  asynchronous, active-low reset.
REQ-005 Port dataIn  input  DATA_WIDTH  parallel word to serialise.
REQ-006 Port dataValid  input  1  dataIn holds a word to transmit.
REQ-007 Port dataReady  output  1  block accepts dataIn this cycle.
REQ-008 Port seqReady  input  1  downstream consumes the current serial bit this cycle.
REQ-009 Port seqOut  output  1  serial bit stream, LSB first, parity bit last.
REQ-010 Port seqValid  output  1  seqOut carries a frame bit.
REQ-011 Port lastOut  output  1  current seqOut bit is the parity bit.

Function
REQ-012 The FSM SHALL have exactly three states: Idle, Data and Parity.
REQ-013 A word transfer SHALL occur on a posedge where dataValid=1 and dataReady=1.
- dataIn captured into the shift register.
- Parity accumulator loaded with ODD_PARITY.
- Bit counter cleared.
- Next state Data.
REQ-014 A bit transfer SHALL occur on a posedge where seqValid=1 and seqReady=1; with seqReady=0, the state, shift register, counter and accumulator SHALL hold.
REQ-015 In Data, seqValid=1, seqOut=shift[0], lastOut=0.
- Each bit transfer XORs shift[0] into the accumulator, shifts right by one and increments the counter.
- The transfer of bit DATA_WIDTH-1 moves the FSM to Parity.
REQ-016 In Parity, seqValid=1, lastOut=1, seqOut=accumulator.
- The total number of ones in the frame is even when ODD_PARITY=0 and odd when ODD_PARITY=1.
REQ-017 dataReady SHALL equal 1 in Idle, and in Parity only when seqReady=1; it SHALL be 0 in Data and while rst=0.
REQ-018 From Parity, a bit transfer SHALL go to Data if a word transfer occurs in the same cycle; otherwise it SHALL go to Idle.
- Back-to-back frames have no gap cycle.
- Sustained throughput is one word per DATA_WIDTH+1 cycles.
REQ-019 In Idle, seqValid=0, seqOut=0 and lastOut=0; dataIn is ignored while dataReady=0.
REQ-020 The first bit of a frame SHALL appear on seqOut in the cycle after its word transfer.
- With seqReady held at 1, the frame occupies exactly DATA_WIDTH+1 consecutive seqValid cycles.
REQ-021 dataIn and dataValid changes during Data or Parity SHALL NOT alter the frame in flight.

Reset
REQ-022 While rst=0, independent of clk:
- FSM is Idle.
- Shift register is 0.
- Counter is 0.
- Accumulator equals ODD_PARITY.
- Outputs: seqValid=0, seqOut=0, lastOut=0, dataReady=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; no partial bits or parity bit SHALL appear after rst returns to 1.
REQ-024 On the first posedge after rst deasserts, the block SHALL be in Idle with dataReady=1.

Verification (DATA_WIDTH=8, seqReady=1 unless stated)
REQ-025 Even parity, dataIn=0xA5 -> seqOut 1,0,1,0,0,1,0,1 then parity 0 with lastOut=1 on the 9th bit; then seqValid=0.
REQ-026 Even parity, dataIn=0x07 -> seqOut 1,1,1,0,0,0,0,0 then parity 1; ODD_PARITY=1 with dataIn=0x00 -> eight 0s then parity 1.
REQ-027 dataValid held with 0x01 then 0x03 -> 18 consecutive seqValid cycles.
- Word 2 is accepted in the Parity cycle of word 1.
- Parity bits are 1 and 0.
- No idle cycle between frames.
REQ-028 0xF0 with seqReady=0 for 3 cycles while bit 4 is presented -> seqOut holds 1 and the counter holds for those cycles; the frame then completes with parity 0.
REQ-029 rst pulsed low while bit 5 of 0xFF is presented -> seqValid=0 at once and no parity bit appears; the next word 0x80 is sent in full with parity 1.
REQ-030 seqOut looped into the team's serial parity checker, with both reset together and even parity -> the checker's even-detect output is 1 during the cycle after every parity bit.
